// File: rtl/pipe_stage_skid.sv
// Pipeline-register stage with valid/ready handshake and a two-entry (main + skid) buffer.
// in_ready comes straight from a flop; flush turns both entries into bubbles; stall_cnt saturates.
module pipe_stage_skid #(
  parameter int                 CTRL_W    = 4,
  parameter int                 DATA_W    = 69,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h0000_0013),
  parameter int                 STALL_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [DATA_W-1:0]  out_data,
  output logic [INSTR_W-1:0] out_instr,
  output logic               skid_full,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic [DATA_W-1:0]  data;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  // Encoding is {main_v, skid_v}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b10,
    S_TWO   = 2'b11
  } state_e;

  localparam entry_t BUBBLE = '{ctrl: '0, data: '0, instr: NOP_INSTR};

  state_e             state_q, state_d;
  entry_t             main_q, main_d;
  entry_t             skid_q, skid_d;
  entry_t             in_beat;
  logic               in_ready_q;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               acc, pop;

  assign in_beat = '{ctrl: in_ctrl, data: in_data, instr: in_instr};
  assign acc     = in_valid & in_ready_q;
  assign pop     = out_valid & out_ready;

  // NOTE: every variable gets its default before any branch, so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (acc) begin
            main_d  = in_beat;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (pop && acc) begin
            main_d = in_beat;
          end else if (pop) begin
            main_d  = BUBBLE;
            state_d = S_EMPTY;
          end else if (acc) begin
            skid_d  = in_beat;
            state_d = S_TWO;
          end
        end
        S_TWO: begin
          if (pop) begin
            main_d  = skid_q;
            skid_d  = BUBBLE;
            state_d = S_ONE;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  // Flush does not clear the counter; only reset does.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the entry registers are reset too, because their contents drive the outputs directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      main_q     <= BUBBLE;
      skid_q     <= BUBBLE;
      in_ready_q <= 1'b1;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != S_TWO);
      stall_q    <= stall_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != S_EMPTY);
  assign skid_full = (state_q == S_TWO);
  assign out_ctrl  = main_q.ctrl;
  assign out_data  = main_q.data;
  assign out_instr = main_q.instr;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus a random run checked
// against a queue-based model of the stage (0..2 beats held, head is presented).
module tb_pipe_stage_skid;

  localparam int CTRL_W  = 4;
  localparam int DATA_W  = 69;
  localparam int INSTR_W = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] IA  = 32'h00A0_0093;
  localparam logic [31:0] IB  = 32'h00B0_0113;
  localparam logic [31:0] IC  = 32'h00C0_0193;

  typedef struct packed {
    logic [CTRL_W-1:0]  ctrl;
    logic [DATA_W-1:0]  data;
    logic [INSTR_W-1:0] instr;
  } beat_t;

  localparam beat_t BUBBLE_TB = '{ctrl: '0, data: '0, instr: NOP};

  logic               clk, rst, flush;
  logic               in_valid, in_ready, out_ready, out_valid, skid_full;
  logic [CTRL_W-1:0]  in_ctrl, out_ctrl;
  logic [DATA_W-1:0]  in_data, out_data;
  logic [INSTR_W-1:0] in_instr, out_instr;
  logic [15:0]        stall_cnt;

  logic               s_in_ready, s_out_valid, s_skid_full;
  logic [CTRL_W-1:0]  s_out_ctrl;
  logic [DATA_W-1:0]  s_out_data;
  logic [INSTR_W-1:0] s_out_instr;
  logic [3:0]         s_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  beat_t       mq[$];
  int unsigned m_stall, m_stall4;

  pipe_stage_skid dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_instr(out_instr),
    .skid_full(skid_full), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.STALL_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_instr(in_instr),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_ctrl(s_out_ctrl), .out_data(s_out_data), .out_instr(s_out_instr),
    .skid_full(s_skid_full), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_stall  = 0;
    m_stall4 = 0;
  endtask

  task automatic compare_all(input string ph);
    beat_t e;
    e = (mq.size() > 0) ? mq[0] : BUBBLE_TB;
    check({ph, "_valid"},  128'(out_valid), 128'(mq.size() > 0));
    check({ph, "_ctrl"},   128'(out_ctrl),  128'(e.ctrl));
    check({ph, "_data"},   128'(out_data),  128'(e.data));
    check({ph, "_instr"},  128'(out_instr), 128'(e.instr));
    check({ph, "_inrdy"},  128'(in_ready),  128'(mq.size() < 2));
    check({ph, "_skid"},   128'(skid_full), 128'(mq.size() == 2));
    check({ph, "_stall"},  128'(stall_cnt), 128'(m_stall));
    check({ph, "_stall4"}, 128'(s_stall_cnt), 128'(m_stall4));
    check({ph, "_sinstr"}, 128'(s_out_instr), 128'(e.instr));
  endtask

  // Next-state of the model from the current inputs, applied just before the edge.
  task automatic model_update();
    int sz;
    bit acc, pop;
    sz  = mq.size();
    acc = in_valid && (sz < 2);
    pop = (sz > 0) && out_ready;
    if (sz > 0 && !out_ready) begin
      if (m_stall < 32'hFFFF) m_stall++;
      if (m_stall4 < 15) m_stall4++;
    end
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back('{ctrl: in_ctrl, data: in_data, instr: in_instr});
    end
  endtask

  task automatic tick();
    #3;
    compare_all("cyc");
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] instr, input bit rdy, input bit fl);
    logic [95:0] r;
    r         = {$urandom(), $urandom(), $urandom()};
    in_valid  = v;
    in_instr  = instr;
    in_ctrl   = r[95:92];
    in_data   = r[68:0];
    out_ready = rdy;
    flush     = fl;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    model_reset();

    // T1: reset values while rst is held, at a random time.
    #($urandom_range(3, 17));
    compare_all("t1");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // T2: streaming with out_ready=1, 1-cycle latency, no gaps.
    drive(1'b1, IA, 1'b1, 1'b0); tick();
    check("t2_a", 128'(out_instr), 128'(IA));
    drive(1'b1, IB, 1'b1, 1'b0); tick();
    check("t2_b", 128'(out_instr), 128'(IB));
    drive(1'b1, IC, 1'b1, 1'b0); tick();
    check("t2_c", 128'(out_instr), 128'(IC));
    check("t2_cv", 128'(out_valid), 128'(1));
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    check("t2_drain", 128'(out_valid), 128'(0));

    // T3: back-pressure fills the skid entry, then drains in order.
    drive(1'b1, IA, 1'b0, 1'b0); tick();
    drive(1'b1, IB, 1'b0, 1'b0); tick();
    check("t3_inrdy", 128'(in_ready), 128'(0));
    check("t3_skid", 128'(skid_full), 128'(1));
    check("t3_hold_a", 128'(out_instr), 128'(IA));
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_held", 128'(out_instr), 128'(IA));
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
    check("t3_then_b", 128'(out_instr), 128'(IB));
    check("t3_skid_free", 128'(skid_full), 128'(0));
    tick();
    check("t3_empty", 128'(out_valid), 128'(0));
    check("t3_stall", 128'(stall_cnt), 128'(4));

    // T4: flush in TWO with in_valid=1.
    drive(1'b1, IA, 1'b0, 1'b0); tick();
    drive(1'b1, IB, 1'b0, 1'b0); tick();
    check("t4_two", 128'(skid_full), 128'(1));
    drive(1'b1, IC, 1'b0, 1'b1); tick();
    check("t4_valid", 128'(out_valid), 128'(0));
    check("t4_ctrl", 128'(out_ctrl), 128'(0));
    check("t4_instr", 128'(out_instr), 128'(NOP));
    check("t4_skid", 128'(skid_full), 128'(0));
    check("t4_inrdy", 128'(in_ready), 128'(1));

    // T5: 4-bit counter saturates at 15 while the 16-bit one keeps counting.
    drive(1'b1, IA, 1'b0, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    check("t5_sat", 128'(s_stall_cnt), 128'(15));
    check("t5_wide", 128'(stall_cnt), 128'(26));
    drive(1'b0, 32'h0, 1'b0, 1'b1); tick();

    // T6: random traffic, with one asynchronous reset mid-run.
    for (int i = 0; i < 10000; i++) begin
      if (i == 5000) begin
        #($urandom_range(1, 3));
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      drive(1'($urandom_range(0, 1)), $urandom(), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 31) == 0));
      tick();
    end

    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("end_empty", 128'(out_valid), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
